dict_arbiter: RTL and testbench

DICT_ARBITER -- requirements
Module: dict_arbiter

---
 rtl/dict_arb_pkg.sv | 17 +
 rtl/dict_arb_vpipe.sv | 32 +++
 rtl/dict_arbiter.sv | 122 ++++++++++++
 tb/tb_dict_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dict_arb_pkg.sv
// Shared definitions for the dictionary ROM arbiter: state encoding and
// default geometry/timing constants.
package dict_arb_pkg;

    // Owner of the previous cycle's grant
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 16;
    localparam int RD_LAT_DEF    = 1;

endpackage

// File: rtl/dict_arb_vpipe.sv
// RD_LAT-deep shift register carrying the {port1, port0} grant bits so that
// each grant re-emerges as a one-cycle read-valid pulse aligned with ROM data.
module dict_arb_vpipe
    import dict_arb_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [1:0] stage [RD_LAT];

    // Shift grant bits one stage per cycle; reset discards in-flight reads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= 2'b00;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[RD_LAT-1];

endmodule

// File: rtl/dict_arbiter.sv
// Two-port arbiter in front of a shared dictionary ROM. Port 0 is the CPU
// dictmem path, port 1 the decrypt search engine. Grants are combinational;
// an owner keeps the ROM while requesting, but yields after MAX_BURST
// consecutive grants if the other port is waiting. Read data returns
// RD_LAT cycles after the grant, qualified by rvalidN.
//
// Handshake: reqN/addrN are held by the requester until it sees gntN high in
// the same cycle; each gntN cycle is exactly one accepted read and produces
// exactly one rvalidN pulse RD_LAT cycles later, which cannot be stalled.
module dict_arbiter
    import dict_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output state_t            fsm_state
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    state_t           state;
    logic             ptr;        // port with priority on a tie from IDLE
    logic [CNT_W-1:0] burst_cnt;
    logic             gnt0_raw;
    logic             gnt1_raw;
    logic [1:0]       vld;

    // Grant decision from current owner, requests, pointer and burst length
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        case (state)
            OWN0: begin
                if (req0) begin
                    if (req1 && burst_cnt == CNT_MAX) gnt1_raw = 1'b1;
                    else                              gnt0_raw = 1'b1;
                end else if (req1) begin
                    gnt1_raw = 1'b1;
                end
            end
            OWN1: begin
                if (req1) begin
                    if (req0 && burst_cnt == CNT_MAX) gnt0_raw = 1'b1;
                    else                              gnt1_raw = 1'b1;
                end else if (req0) begin
                    gnt0_raw = 1'b1;
                end
            end
            default: begin
                if (req0 && req1) begin
                    gnt0_raw = ~ptr;
                    gnt1_raw = ptr;
                end else begin
                    gnt0_raw = req0;
                    gnt1_raw = req1;
                end
            end
        endcase
    end

    // Grants are forced low while reset is held, regardless of requests
    assign gnt0     = gnt0_raw & reset;
    assign gnt1     = gnt1_raw & reset;
    assign rom_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

    // Track owner, round-robin pointer and consecutive-grant count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            burst_cnt <= '0;
        end else if (gnt0) begin
            state     <= OWN0;
            ptr       <= 1'b1;
            if (state == OWN0)
                burst_cnt <= (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + 1'b1;
            else
                burst_cnt <= CNT_W'(1);
        end else if (gnt1) begin
            state     <= OWN1;
            ptr       <= 1'b0;
            if (state == OWN1)
                burst_cnt <= (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + 1'b1;
            else
                burst_cnt <= CNT_W'(1);
        end else begin
            state     <= IDLE;
            burst_cnt <= '0;
        end
    end

    dict_arb_vpipe #(.RD_LAT(RD_LAT)) u_vpipe (
        .clock (clock),
        .reset (reset),
        .din   ({gnt1, gnt0}),
        .dout  (vld)
    );

    assign rvalid0   = vld[0];
    assign rvalid1   = vld[1];
    assign rdata0    = rom_data;
    assign rdata1    = rom_data;
    assign fsm_state = state;

endmodule

// File: tb/tb_dict_arbiter.sv
// Directed bench for dict_arbiter: a per-cycle driver checks grants and ROM
// address against hand-computed values and queues the expected read words;
// a monitor pops and checks them whenever an rvalid appears.
module tb_dict_arbiter;
    import dict_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    state_t        fsm_state;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    int checks = 0;
    int errors = 0;

    dict_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset / ROM model ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {16'hD1C7, 4'h0, a} ^ {a[7:0], 24'h0};
    endfunction

    // One-cycle-latency ROM
    initial rom_data = '0;
    always @(posedge clock) rom_data <= rom_word(rom_addr);

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle, then checks the combinational grant and ROM address.
    task automatic step(input logic rv, input logic r0, input logic [AW-1:0] a0,
                        input logic r1, input logic [AW-1:0] a1,
                        input logic eg0, input logic eg1);
        logic [AW-1:0] ea;
        @(negedge clock);
        reset = rv;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        #1;
        ea = eg0 ? a0 : (eg1 ? a1 : '0);
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        if (eg0) exp_q0.push_back(rom_word(a0));
        if (eg1) exp_q1.push_back(rom_word(a1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (rvalid0) begin
            if (exp_q0.size() == 0) chk("unexpected_rvalid0", 32'(rvalid0), 32'd0);
            else chk("rdata0", rdata0, exp_q0.pop_front());
        end
        if (rvalid1) begin
            if (exp_q1.size() == 0) chk("unexpected_rvalid1", 32'(rvalid1), 32'd0);
            else chk("rdata1", rdata1, exp_q1.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;

        // Reset held with both ports requesting: everything quiet
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 12'h0A0, 1'b1, 12'h0B0, 1'b0, 1'b0);
            chk("rst_state", 32'(fsm_state), 32'(IDLE));
            chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        end

        // Both requesting for 40 cycles: 16 to port 0, 16 to port 1, then port 0
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 12'h0A0, 1'b1, 12'h0B0, (i < 16) || (i >= 32), (i >= 16) && (i < 32));
        end
        idle(2);

        // Single read of word 5 on port 0
        step(1'b1, 1'b1, 12'h005, 1'b0, 12'h000, 1'b1, 1'b0);
        idle(2);

        // Port 1 owns, port 0 joins, port 1 drops: port 0 granted with no gap
        step(1'b1, 1'b0, 12'h000, 1'b1, 12'h020, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b1, 12'h021, 1'b0, 1'b1);
        step(1'b1, 1'b1, 12'h040, 1'b1, 12'h022, 1'b0, 1'b1);
        step(1'b1, 1'b1, 12'h040, 1'b0, 12'h000, 1'b1, 1'b0);
        step(1'b1, 1'b1, 12'h041, 1'b0, 12'h000, 1'b1, 1'b0);
        idle(2);

        // Back-to-back port 1 reads, data must return in order
        step(1'b1, 1'b0, 12'h000, 1'b1, 12'h010, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b1, 12'h011, 1'b0, 1'b1);
        step(1'b1, 1'b0, 12'h000, 1'b1, 12'h012, 1'b0, 1'b1);

        // Port 1 drops req while its reads are in flight; port 0 takes over
        step(1'b1, 1'b1, 12'h3FF, 1'b0, 12'h000, 1'b1, 1'b0);

        // Five idle cycles: back to IDLE with everything low
        idle(5);
        chk("idle_state", 32'(fsm_state), 32'(IDLE));
        chk("idle_rvalid", 32'({rvalid1, rvalid0}), 32'd0);

        // Grant to port 1, then reset right after the granting edge
        step(1'b1, 1'b0, 12'h000, 1'b1, 12'h033, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req1  = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 12'h077, 1'b1, 12'h088, 1'b0, 1'b0);
            chk("rst2_state", 32'(fsm_state), 32'(IDLE));
            chk("rst2_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        end
        // Release with both requesting: port 0 first, then port 0 continues
        step(1'b1, 1'b1, 12'h077, 1'b1, 12'h088, 1'b1, 1'b0);
        step(1'b1, 1'b1, 12'h078, 1'b1, 12'h088, 1'b1, 1'b0);
        idle(3);

        chk("q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
